// File: rtl/spi_flash_resp.sv
// SPI mode-0 read-only flash responder.
// Serves READ_CMD transactions from a 32-bit backing memory, streaming
// bytes MSB first, little-endian within each word, address wrapping at
// 2^ADDR_W. All SPI pins are synchronized into the clk domain.
module spi_flash_resp #(
  parameter logic [7:0] READ_CMD = 8'h03,
  parameter int         ADDR_W   = 24
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              cmd_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    DATA   = 3'd3,
    IGNORE = 3'd4
  } state_t;

  localparam logic [5:0] ADDR_LAST = 6'(ADDR_W - 1);

  // Select byte lane k = bits [8k+7:8k] of a memory word.
  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] sel);
    case (sel)
      2'd0:    lane_byte = word[7:0];
      2'd1:    lane_byte = word[15:8];
      2'd2:    lane_byte = word[23:16];
      default: lane_byte = word[31:24];
    endcase
  endfunction

  logic sclk_meta, sclk_sync, sclk_prev;
  logic cs_meta, cs_sync, cs_prev;
  logic mosi_meta, mosi_sync;
  logic sclk_rise, sclk_fall, cs_fall;

  state_t            state, state_nxt;
  logic [5:0]        bit_cnt, bit_cnt_nxt;
  logic [6:0]        cmd_sh, cmd_sh_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [6:0]        shift, shift_nxt;
  logic              load_pend, load_pend_nxt;
  logic              miso_nxt, ren_nxt, err_nxt, busy_nxt;
  logic [ADDR_W-1:0] maddr_nxt;
  logic [7:0]        lane;

  // Two-flop synchronizers plus one history flop for edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sclk_meta <= 1'b0; sclk_sync <= 1'b0; sclk_prev <= 1'b0;
      cs_meta   <= 1'b1; cs_sync   <= 1'b1; cs_prev   <= 1'b1;
      mosi_meta <= 1'b0; mosi_sync <= 1'b0;
    end else begin
      sclk_meta <= spi_clk;  sclk_sync <= sclk_meta; sclk_prev <= sclk_sync;
      cs_meta   <= spi_cs_n; cs_sync   <= cs_meta;   cs_prev   <= cs_sync;
      mosi_meta <= spi_mosi; mosi_sync <= mosi_meta;
    end
  end

  assign sclk_rise = sclk_sync & ~sclk_prev;
  assign sclk_fall = ~sclk_sync & sclk_prev;
  assign cs_fall   = ~cs_sync & cs_prev;
  assign lane      = lane_byte(mem_rdata, addr[1:0]);

  // Next-state and next-output decode; chip-select release overrides every phase.
  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    cmd_sh_nxt    = cmd_sh;
    addr_nxt      = addr;
    shift_nxt     = shift;
    load_pend_nxt = mem_ren;
    miso_nxt      = 1'b1;
    ren_nxt       = 1'b0;
    maddr_nxt     = mem_addr;
    err_nxt       = 1'b0;
    case (state)
      IDLE: begin
        load_pend_nxt = 1'b0;
        if (cs_fall) begin
          state_nxt   = CMD;
          bit_cnt_nxt = 6'd0;
        end else begin
          state_nxt   = IDLE;
        end
      end
      CMD: begin
        if (sclk_rise) begin
          cmd_sh_nxt  = {cmd_sh[5:0], mosi_sync};
          bit_cnt_nxt = bit_cnt + 6'd1;
          if (bit_cnt == 6'd7) begin
            bit_cnt_nxt = 6'd0;
            if ({cmd_sh, mosi_sync} == READ_CMD) begin
              state_nxt = ADDR;
            end else begin
              state_nxt = IGNORE;
              err_nxt   = 1'b1;
            end
          end else begin
            state_nxt = CMD;
          end
        end else begin
          state_nxt = CMD;
        end
      end
      ADDR: begin
        if (sclk_rise) begin
          addr_nxt    = {addr[ADDR_W-2:0], mosi_sync};
          bit_cnt_nxt = bit_cnt + 6'd1;
          if (bit_cnt == ADDR_LAST) begin
            bit_cnt_nxt = 6'd0;
            state_nxt   = DATA;
            ren_nxt     = 1'b1;
            maddr_nxt   = {addr_nxt[ADDR_W-1:2], 2'b00};
          end else begin
            state_nxt   = ADDR;
          end
        end else begin
          state_nxt = ADDR;
        end
      end
      DATA: begin
        miso_nxt = spi_miso;
        // A fresh byte arrives one clk after each mem_ren; the falling edge
        // that follows bit 0 (bit_cnt back at 0) must not shift.
        if (load_pend) begin
          miso_nxt  = lane[7];
          shift_nxt = lane[6:0];
        end else if (sclk_fall && (bit_cnt != 6'd0)) begin
          miso_nxt  = shift[6];
          shift_nxt = {shift[5:0], 1'b0};
        end else begin
          shift_nxt = shift;
        end
        if (sclk_rise) begin
          bit_cnt_nxt = bit_cnt + 6'd1;
          if (bit_cnt == 6'd7) begin
            bit_cnt_nxt = 6'd0;
            addr_nxt    = addr + ADDR_W'(1);
            ren_nxt     = 1'b1;
            maddr_nxt   = {addr_nxt[ADDR_W-1:2], 2'b00};
          end else begin
            ren_nxt     = 1'b0;
          end
        end else begin
          bit_cnt_nxt = bit_cnt;
        end
      end
      IGNORE: begin
        state_nxt = IGNORE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if ((state != IDLE) && cs_sync) begin
      state_nxt     = IDLE;
      bit_cnt_nxt   = 6'd0;
      miso_nxt      = 1'b1;
      ren_nxt       = 1'b0;
      load_pend_nxt = 1'b0;
    end else begin
      load_pend_nxt = load_pend_nxt;
    end
    busy_nxt = (state_nxt != IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      bit_cnt   <= 6'd0;
      cmd_sh    <= 7'd0;
      addr      <= '0;
      shift     <= 7'd0;
      load_pend <= 1'b0;
      spi_miso  <= 1'b1;
      mem_ren   <= 1'b0;
      mem_addr  <= '0;
      busy      <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      cmd_sh    <= cmd_sh_nxt;
      addr      <= addr_nxt;
      shift     <= shift_nxt;
      load_pend <= load_pend_nxt;
      spi_miso  <= miso_nxt;
      mem_ren   <= ren_nxt;
      mem_addr  <= maddr_nxt;
      busy      <= busy_nxt;
      cmd_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_spi_flash_resp.sv
// Scoreboard bench for spi_flash_resp: an SPI master drives transactions,
// a reference model pushes expected MISO bits and memory addresses into
// queues, and monitors pop and compare as the DUT produces them.
`timescale 1ns/1ps
module tb_spi_flash_resp;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        spi_clk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        mem_ren;
  logic [23:0] mem_addr;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy;
  logic        cmd_err;
  logic        cmd_err_prev = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int err_seen = 0;
  int err_exp  = 0;

  bit          exp_bits[$];
  logic [23:0] exp_addr[$];

  spi_flash_resp #(.READ_CMD(8'h03), .ADDR_W(24)) dut (
    .clk(clk), .resetn(resetn), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .mem_ren(mem_ren),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  // Backing memory contents: a few fixed words, a hash elsewhere.
  function automatic logic [31:0] word_at(input logic [23:0] a);
    case (a)
      24'h000010: return 32'h44332211;
      24'hFFFFFC: return 32'hDDCCBBAA;
      24'h000000: return 32'h87654321;
      default:    return {a[15:0] ^ 16'hC3A5, a[23:8]};
    endcase
  endfunction

  // Byte view of memory: little-endian lanes within each word.
  function automatic logic [7:0] byte_at(input logic [23:0] b);
    logic [31:0] w;
    w = word_at(b - (b % 24'd4));
    return 8'(w >> (8 * int'(b % 24'd4)));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: data valid the clk after a read strobe, noise otherwise.
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= word_at(mem_addr);
    else         mem_rdata <= $urandom;
  end

  // Monitor: read strobes against expected addresses, cmd_err pulse shape.
  always @(negedge clk) begin
    if (resetn && mem_ren) begin
      if (exp_addr.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL mem_ren_unexpected: got strobe at 0x%0h, expected none", mem_addr);
      end else begin
        check("mem_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
      end
    end
    if (cmd_err) begin
      err_seen++;
      check("cmd_err_width", 32'(cmd_err_prev), 32'd0);
    end
    cmd_err_prev = cmd_err;
  end

  // Monitor: MISO as the master samples it on each spi_clk rising edge.
  always @(posedge spi_clk) begin
    if (!spi_cs_n && resetn) begin
      if (exp_bits.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL miso_unexpected: got bit %0b, expected no sample", spi_miso);
      end else begin
        check("miso_bit", 32'(spi_miso), 32'(exp_bits.pop_front()));
      end
    end
  end

  // Put the SPI master at a random phase relative to clk, never on a rising clk edge.
  task automatic align();
    @(posedge clk);
    #($urandom_range(1, 9));
  endtask

  task automatic idle_checks(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_miso"}, 32'(spi_miso), 32'd1);
    check({tag, "_cmd_err_count"}, 32'(err_seen), 32'(err_exp));
    check({tag, "_miso_queue_left"}, 32'(exp_bits.size()), 32'd0);
    check({tag, "_addr_queue_left"}, 32'(exp_addr.size()), 32'd0);
  endtask

  // Full transaction: opcode, 24-bit address, then dclk data clocks.
  task automatic run_txn(input logic [7:0] op, input logic [23:0] a, input int dclk, input int half);
    logic [31:0] hdr;
    logic [23:0] ba;
    logic [7:0]  b;
    hdr = {op, a};
    for (int i = 0; i < 32; i++) exp_bits.push_back(1'b1);
    if (op == 8'h03) begin
      for (int j = 0; j < dclk; j++) begin
        b = byte_at(a + 24'(j / 8));
        exp_bits.push_back(b[7 - (j % 8)]);
      end
      for (int i = 0; i <= dclk / 8; i++) begin
        ba = a + 24'(i);
        exp_addr.push_back(ba - (ba % 24'd4));
      end
    end else begin
      for (int j = 0; j < dclk; j++) exp_bits.push_back(1'b1);
      err_exp++;
    end
    align();
    spi_cs_n = 1'b0;
    for (int i = 0; i < 32 + dclk; i++) begin
      spi_mosi = (i < 32) ? hdr[31 - i] : 1'($urandom);
      #(half); spi_clk = 1'b1;
      #(half); spi_clk = 1'b0;
    end
    #(half);
    check("busy_selected", 32'(busy), 32'd1);
    spi_cs_n = 1'b1;
    #(2 * half);
    idle_checks("after_txn");
  endtask

  // Reset lands in the middle of the address phase.
  task automatic reset_in_addr(input logic [23:0] a, input int half);
    logic [15:0] hdr;
    hdr = {8'h03, a[23:16]};
    for (int i = 0; i < 16; i++) exp_bits.push_back(1'b1);
    align();
    spi_cs_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      spi_mosi = hdr[15 - i];
      #(half); spi_clk = 1'b1;
      #(half); spi_clk = 1'b0;
    end
    #(half);
    resetn = 1'b0;
    #23;
    check("rst_mid_miso", 32'(spi_miso), 32'd1);
    check("rst_mid_mem_ren", 32'(mem_ren), 32'd0);
    check("rst_mid_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_cmd_err", 32'(cmd_err), 32'd0);
    spi_cs_n = 1'b1;
    #20;
    resetn = 1'b1;
    #(2 * half);
    idle_checks("after_reset");
  endtask

  // Watchdog: the bench must always terminate.
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  op;
    logic [23:0] a;
    #23;
    check("reset_miso", 32'(spi_miso), 32'd1);
    check("reset_mem_ren", 32'(mem_ren), 32'd0);
    check("reset_mem_addr", 32'(mem_addr), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_cmd_err", 32'(cmd_err), 32'd0);
    resetn = 1'b1;
    #40;

    run_txn(8'h03, 24'h000010, 32, 50);   // aligned read, four bytes
    run_txn(8'h03, 24'hFFFFFE, 24, 50);   // unaligned start, address wrap
    run_txn(8'h9F, 24'h123456, 24, 50);   // unsupported opcode
    run_txn(8'h03, 24'h000000, 4, 50);    // abort mid-byte
    run_txn(8'h03, 24'h000000, 16, 50);   // clean read after abort
    reset_in_addr(24'h000010, 50);
    run_txn(8'h03, 24'h000010, 32, 60);   // read after reset
    for (int k = 0; k < 4; k++) run_txn(8'h03, 24'h000010, 32, 40);  // minimum half period
    for (int k = 0; k < 10; k++) begin
      op = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h03;
      a  = 24'($urandom);
      run_txn(op, a, $urandom_range(0, 40), 10 * $urandom_range(4, 7));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
